digest_rx: RTL and testbench

DIGEST_RX -- requirements
Module: digest_rx

---
 rtl/digest_pkg.sv | 13 +
 rtl/byte_deser.sv | 33 +++
 rtl/digest_rx.sv | 138 +++++++++++++
 tb/tb_digest_rx.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/digest_pkg.sv
// Shared definitions for the digest receiver: FSM state encoding and the
// good-frame counter width.
package digest_pkg;

  localparam int unsigned FRAME_CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/byte_deser.sv
// Byte deserializer: shifts bytes in LSB-first and counts accepted bytes of
// the current frame.
//   clk, rst_n : clock, synchronous active-low reset
//   shift      : accept data_in this cycle
//   first      : accepted byte is the first of a frame (count restarts at 1)
//   data_in    : byte to shift in
//   shreg      : reassembly register, newest byte in the top byte lane
//   cnt        : accepted bytes in the current frame
module byte_deser #(
  parameter int unsigned W = 32,
  localparam int unsigned CNT_W = $clog2(W) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               shift,
  input  logic               first,
  input  logic [7:0]         data_in,
  output logic [W*8-1:0]     shreg,
  output logic [CNT_W-1:0]   cnt
);

  // Right shift: after W bytes, byte k sits in bits [8k+7:8k].
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (shift) begin
      shreg <= {data_in, shreg[W*8-1:8]};
      cnt   <= first ? CNT_W'(1) : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/digest_rx.sv
// Digest receiver: reassembles a W-byte digest from a byte stream, compares
// it with exp_in, hands it to a consumer with valid/ready and records sticky
// framing errors.
//   clk, rst_n     : clock, synchronous active-low reset
//   data_in/dv_in  : byte stream, LSB first, no backpressure
//   data_end       : last byte of a frame (qualified by dv_in)
//   exp_in         : expected digest
//   clr_err        : clears sticky error flags (a new error wins)
//   digest_out     : reassembled digest, held while digest_valid
//   digest_valid/digest_ready : output handshake
//   match          : digest_out == exp_in at frame completion
//   err_len/err_gap/err_ovf   : sticky length, gap and overflow errors
//   frame_cnt      : saturating count of good frames
module digest_rx
  import digest_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             data_in,
  input  logic                   dv_in,
  input  logic                   data_end,
  input  logic [W*8-1:0]         exp_in,
  input  logic                   clr_err,
  output logic [W*8-1:0]         digest_out,
  output logic                   digest_valid,
  input  logic                   digest_ready,
  output logic                   match,
  output logic                   err_len,
  output logic                   err_gap,
  output logic                   err_ovf,
  output logic [FRAME_CNT_W-1:0] frame_cnt
);

  localparam int unsigned DW    = W * 8;
  localparam int unsigned CNT_W = $clog2(W) + 1;

  state_t           state;
  logic             drop;
  logic [DW-1:0]    shreg;
  logic [CNT_W-1:0] cnt;

  logic             idle_rules_c;
  logic             shift_c;
  logic             last_c;
  logic [DW-1:0]    shreg_nxt_c;

  // A byte arriving in IDLE, or in the HOLD cycle that completes a transfer,
  // is handled by the IDLE rules so back-to-back frames lose nothing.
  always_comb begin
    idle_rules_c = (state == ST_IDLE) || ((state == ST_HOLD) && digest_ready);
    shift_c      = dv_in && ((idle_rules_c && !drop) || (state == ST_RECV));
    last_c       = (cnt == CNT_W'(W - 1));
    shreg_nxt_c  = {data_in, shreg[DW-1:8]};
  end

  byte_deser #(.W(W)) u_deser (
    .clk     (clk),
    .rst_n   (rst_n),
    .shift   (shift_c),
    .first   (idle_rules_c),
    .data_in (data_in),
    .shreg   (shreg),
    .cnt     (cnt)
  );

  // Frame FSM, error flags and digest capture. clr_err is applied first so a
  // later error assignment in the same cycle takes precedence.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      drop         <= 1'b0;
      digest_out   <= '0;
      digest_valid <= 1'b0;
      match        <= 1'b0;
      err_len      <= 1'b0;
      err_gap      <= 1'b0;
      err_ovf      <= 1'b0;
      frame_cnt    <= '0;
    end else begin
      if (clr_err) begin
        err_len <= 1'b0;
        err_gap <= 1'b0;
        err_ovf <= 1'b0;
      end

      case (state)
        ST_IDLE: ;
        ST_RECV: begin
          if (!dv_in) begin
            err_gap <= 1'b1;
            drop    <= 1'b1;
            state   <= ST_IDLE;
          end else if (data_end) begin
            if (last_c) begin
              digest_out   <= shreg_nxt_c;
              match        <= (shreg_nxt_c == exp_in);
              digest_valid <= 1'b1;
              state        <= ST_HOLD;
              if (frame_cnt != '1) frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
            end else begin
              err_len <= 1'b1;
              state   <= ST_IDLE;
            end
          end else if (last_c) begin
            // Frame overran W bytes: drop the rest up to its data_end.
            err_len <= 1'b1;
            drop    <= 1'b1;
            state   <= ST_IDLE;
          end
        end
        ST_HOLD: begin
          if (digest_ready) begin
            digest_valid <= 1'b0;
            state        <= ST_IDLE;
          end else if (dv_in) begin
            err_ovf <= 1'b1;
            drop    <= !data_end;
          end
        end
        default: state <= ST_IDLE;
      endcase

      // IDLE byte handling (also in the transfer cycle out of HOLD).
      if (idle_rules_c && dv_in) begin
        if (drop) begin
          if (data_end) drop <= 1'b0;
        end else if (data_end) begin
          err_len <= 1'b1;
        end else begin
          state <= ST_RECV;
        end
      end
    end
  end

endmodule

// File: tb/tb_digest_rx.sv
module tb_digest_rx;
  import digest_pkg::*;

  localparam int unsigned W = 32;

  logic                   clk;
  logic                   rst_n;
  logic [7:0]             data_in;
  logic                   dv_in;
  logic                   data_end;
  logic [W*8-1:0]         exp_in;
  logic                   clr_err;
  logic [W*8-1:0]         digest_out;
  logic                   digest_valid;
  logic                   digest_ready;
  logic                   match;
  logic                   err_len;
  logic                   err_gap;
  logic                   err_ovf;
  logic [FRAME_CNT_W-1:0] frame_cnt;

  int checks;
  int failures;

  digest_rx #(.W(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .data_in      (data_in),
    .dv_in        (dv_in),
    .data_end     (data_end),
    .exp_in       (exp_in),
    .clr_err      (clr_err),
    .digest_out   (digest_out),
    .digest_valid (digest_valid),
    .digest_ready (digest_ready),
    .match        (match),
    .err_len      (err_len),
    .err_gap      (err_gap),
    .err_ovf      (err_ovf),
    .frame_cnt    (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected digest of a frame whose byte k is base+k.
  function automatic logic [255:0] frame_val(input logic [7:0] base);
    logic [255:0] v;
    v = '0;
    for (int k = 0; k < 32; k++) v[8*k +: 8] = base + 8'(k);
    return v;
  endfunction

  task automatic send_bytes(input logic [7:0] first_val, input int n, input bit with_end);
    for (int i = 0; i < n; i++) begin
      dv_in    = 1'b1;
      data_in  = first_val + 8'(i);
      data_end = with_end && (i == n - 1);
      tick();
    end
    dv_in    = 1'b0;
    data_end = 1'b0;
  endtask

  task automatic ready_pulse();
    digest_ready = 1'b1;
    tick();
    digest_ready = 1'b0;
  endtask

  task automatic clr_pulse();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
  endtask

  initial begin
    logic [255:0] ref1;
    checks   = 0;
    failures = 0;
    rst_n = 1'b0; data_in = '0; dv_in = 1'b0; data_end = 1'b0;
    exp_in = '0; clr_err = 1'b0; digest_ready = 1'b0;
    ref1 = 256'h1f1e1d1c1b1a191817161514131211100f0e0d0c0b0a09080706050403020100;

    // Reset state
    tick(); tick();
    chk("rst_valid", 256'(digest_valid), 256'd0);
    chk("rst_digest", digest_out, 256'd0);
    chk("rst_errs", 256'({err_len, err_gap, err_ovf, match}), 256'd0);
    chk("rst_frame_cnt", 256'(frame_cnt), 256'd0);
    rst_n = 1'b1;
    tick();

    // Good frame 0x00..0x1F
    exp_in = ref1;
    send_bytes(8'h00, 31, 1'b0);
    chk("t1_valid_early", 256'(digest_valid), 256'd0);
    send_bytes(8'h1F, 1, 1'b1);
    chk("t1_valid", 256'(digest_valid), 256'd1);
    chk("t1_digest", digest_out, ref1);
    chk("t1_match", 256'(match), 256'd1);
    chk("t1_frame_cnt", 256'(frame_cnt), 256'd1);
    chk("t1_errs", 256'({err_len, err_gap, err_ovf}), 256'd0);
    ready_pulse();
    chk("t1_released", 256'(digest_valid), 256'd0);

    // Short frame: data_end on byte index 16
    send_bytes(8'h00, 17, 1'b1);
    tick();
    chk("t2_err_len", 256'(err_len), 256'd1);
    chk("t2_no_valid", 256'(digest_valid), 256'd0);
    chk("t2_frame_cnt", 256'(frame_cnt), 256'd1);
    clr_pulse();
    chk("t2_clr", 256'(err_len), 256'd0);
    exp_in = frame_val(8'h40);
    send_bytes(8'h40, 32, 1'b1);
    chk("t2_next_valid", 256'(digest_valid), 256'd1);
    chk("t2_next_digest", digest_out, frame_val(8'h40));
    chk("t2_next_match", 256'(match), 256'd1);
    chk("t2_next_frame_cnt", 256'(frame_cnt), 256'd2);
    ready_pulse();

    // Gap after 10 bytes, remaining 22 dropped
    send_bytes(8'h00, 10, 1'b0);
    tick();
    chk("t3_err_gap", 256'(err_gap), 256'd1);
    send_bytes(8'h0A, 22, 1'b1);
    tick();
    chk("t3_no_valid", 256'(digest_valid), 256'd0);
    chk("t3_err_len", 256'(err_len), 256'd0);
    chk("t3_frame_cnt", 256'(frame_cnt), 256'd2);
    clr_pulse();
    exp_in = frame_val(8'h80);
    send_bytes(8'h80, 32, 1'b1);
    chk("t3_next_valid", 256'(digest_valid), 256'd1);
    chk("t3_next_digest", digest_out, frame_val(8'h80));
    chk("t3_next_frame_cnt", 256'(frame_cnt), 256'd3);
    chk("t3_errs", 256'({err_len, err_gap, err_ovf}), 256'd0);
    ready_pulse();

    // Overflow: second frame while first is held
    exp_in = frame_val(8'hA0);
    send_bytes(8'hA0, 32, 1'b1);
    send_bytes(8'h20, 32, 1'b1);
    chk("t4_err_ovf", 256'(err_ovf), 256'd1);
    chk("t4_err_len", 256'(err_len), 256'd0);
    chk("t4_held_valid", 256'(digest_valid), 256'd1);
    chk("t4_held_digest", digest_out, frame_val(8'hA0));
    chk("t4_held_match", 256'(match), 256'd1);
    chk("t4_frame_cnt", 256'(frame_cnt), 256'd4);
    ready_pulse();
    chk("t4_released", 256'(digest_valid), 256'd0);
    clr_pulse();
    chk("t4_clr", 256'(err_ovf), 256'd0);
    exp_in = frame_val(8'h60);
    send_bytes(8'h60, 32, 1'b1);
    chk("t4_next_digest", digest_out, frame_val(8'h60));
    chk("t4_next_match", 256'(match), 256'd1);
    chk("t4_next_frame_cnt", 256'(frame_cnt), 256'd5);
    ready_pulse();

    // Reset at byte 20 of a frame
    send_bytes(8'h10, 20, 1'b0);
    rst_n = 1'b0; dv_in = 1'b1; data_in = 8'h24;
    tick();
    rst_n = 1'b1; dv_in = 1'b0;
    tick();
    chk("t5_rst_frame_cnt", 256'(frame_cnt), 256'd0);
    chk("t5_rst_errs", 256'({err_len, err_gap, err_ovf}), 256'd0);
    chk("t5_rst_valid", 256'(digest_valid), 256'd0);
    exp_in = frame_val(8'h10);
    send_bytes(8'h10, 32, 1'b1);
    chk("t5_digest", digest_out, frame_val(8'h10));
    chk("t5_match", 256'(match), 256'd1);
    chk("t5_frame_cnt", 256'(frame_cnt), 256'd1);
    chk("t5_errs", 256'({err_len, err_gap, err_ovf}), 256'd0);
    ready_pulse();

    // Ready in the same cycle as the next frame's first byte
    exp_in = frame_val(8'h30);
    send_bytes(8'h30, 32, 1'b1);
    chk("t6_first_valid", 256'(digest_valid), 256'd1);
    exp_in = frame_val(8'h50);
    digest_ready = 1'b1;
    send_bytes(8'h50, 1, 1'b0);
    digest_ready = 1'b0;
    chk("t6_transfer", 256'(digest_valid), 256'd0);
    send_bytes(8'h51, 31, 1'b1);
    chk("t6_valid", 256'(digest_valid), 256'd1);
    chk("t6_digest", digest_out, frame_val(8'h50));
    chk("t6_match", 256'(match), 256'd1);
    chk("t6_frame_cnt", 256'(frame_cnt), 256'd3);
    chk("t6_errs", 256'({err_len, err_gap, err_ovf}), 256'd0);
    ready_pulse();

    // Mismatching expected digest
    send_bytes(8'h70, 32, 1'b1);
    chk("t7_digest", digest_out, frame_val(8'h70));
    chk("t7_match", 256'(match), 256'd0);
    chk("t7_frame_cnt", 256'(frame_cnt), 256'd4);
    ready_pulse();

    // Error set wins over simultaneous clr_err
    send_bytes(8'h00, 1, 1'b0);
    clr_err = 1'b1;
    send_bytes(8'h01, 1, 1'b1);
    clr_err = 1'b0;
    chk("t8_err_wins", 256'(err_len), 256'd1);
    chk("t8_no_valid", 256'(digest_valid), 256'd0);
    chk("t8_frame_cnt", 256'(frame_cnt), 256'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
